// File: rtl/input_conditioner.sv
// input_conditioner: per-bit debounce filter, edge detector and sticky
// interrupt-pending latch for synchronized GPIO/button inputs.
// Optional macro INPUT_COND_BYPASS_EN adds bypass_i. Bits selected by bypass_i
// follow sync_i every cycle while edge and pending logic keep running.
module input_conditioner #(
    parameter int unsigned      Width      = 8,
    parameter int unsigned      CntWidth   = 16,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    sync_i,
    input  logic [CntWidth-1:0] debounce_cyc_i,
    input  logic [Width-1:0]    irq_en_rise_i,
    input  logic [Width-1:0]    irq_en_fall_i,
    input  logic [Width-1:0]    irq_clr_i,
`ifdef INPUT_COND_BYPASS_EN
    input  logic [Width-1:0]    bypass_i,
`endif
    output logic [Width-1:0]    filt_o,
    output logic [Width-1:0]    rise_o,
    output logic [Width-1:0]    fall_o,
    output logic [Width-1:0]    irq_pend_o,
    output logic                irq_o
);

    logic [CntWidth-1:0] cnt_q [Width];
    logic [Width-1:0]    bypass;
    logic [Width-1:0]    differ;
    logic [Width-1:0]    expired;
    logic [Width-1:0]    take;
    logic [Width-1:0]    set;

`ifdef INPUT_COND_BYPASS_EN
    assign bypass = bypass_i;
`else
    assign bypass = '0;
`endif

    assign differ = sync_i ^ filt_o;
    assign take   = differ & (expired | bypass);
    assign set    = (rise_o & irq_en_rise_i) | (fall_o & irq_en_fall_i);

    // Threshold compare per bit; >= so a lowered threshold fires immediately.
    always_comb begin
        expired = '0;
        for (int b = 0; b < Width; b++) begin
            expired[b] = (cnt_q[b] >= debounce_cyc_i);
        end
    end

    // Debounce counters: clear on agreement, on acceptance, or in bypass.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < Width; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < Width; b++) begin
                if (bypass[b] || !differ[b] || expired[b]) begin
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CntWidth'(1);
                end
            end
        end
    end

    // Filtered level and edge pulses, updated together on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_o <= ResetValue;
            rise_o <= '0;
            fall_o <= '0;
        end else begin
            filt_o <= (filt_o & ~take) | (sync_i & take);
            rise_o <= take & sync_i;
            fall_o <= take & ~sync_i;
        end
    end

    // Sticky pending bits; a new set beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_pend_o <= '0;
        end else begin
            irq_pend_o <= set | (irq_pend_o & ~irq_clr_i);
        end
    end

    assign irq_o = |irq_pend_o;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner.
// Expected outputs are pushed when a step is driven and popped one edge later.
module tb_input_conditioner;

    typedef struct packed {
        logic [7:0] filt;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] pend;
        logic       irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sync = '0;
    logic [15:0] deb = 16'd3;
    logic [7:0]  en_r = '0;
    logic [7:0]  en_f = '0;
    logic [7:0]  clr = '0;
    logic [7:0]  bypass = '0;
    logic [7:0]  filt, rise, fall, pend;
    logic        irq;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    input_conditioner #(.Width(8), .CntWidth(16), .ResetValue(8'h00)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sync_i         (sync),
        .debounce_cyc_i (deb),
        .irq_en_rise_i  (en_r),
        .irq_en_fall_i  (en_f),
        .irq_clr_i      (clr),
`ifdef INPUT_COND_BYPASS_EN
        .bypass_i       (bypass),
`endif
        .filt_o         (filt),
        .rise_o         (rise),
        .fall_o         (fall),
        .irq_pend_o     (pend),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] f, input logic [7:0] r,
                                input logic [7:0] fl, input logic [7:0] p);
        exp_t x;
        x.filt = f;
        x.rise = r;
        x.fall = fl;
        x.pend = p;
        x.irq  = (p != 8'h00);
        return x;
    endfunction

    function automatic exp_t obs();
        exp_t x;
        x.filt = filt;
        x.rise = rise;
        x.fall = fall;
        x.pend = pend;
        x.irq  = irq;
        return x;
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("filt=%h rise=%h fall=%h pend=%h irq=%b",
                         x.filt, x.rise, x.fall, x.pend, x.irq);
    endfunction

    // Drive one cycle of stimulus, record its expected outcome, advance one edge.
    task automatic apply(input logic [7:0] s, input logic [7:0] c, input exp_t e);
        sync = s;
        clr  = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sync = '0;
        clr = '0;
        en_r = '0;
        en_f = '0;
        bypass = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got, e;
        exp_t e_t[6];
        deb = 16'd3;
        #3;
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00));
        got = obs(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_hold: got %s, expected %s", fmt(got), fmt(e));
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) e_t[i] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        e_t[5] = mk(8'h01, 8'h01, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                #2 rst = 1'b1;
                #1;
                exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00));
                got = obs(); e = exp_q.pop_front(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL reset_async: got %s, expected %s", fmt(got), fmt(e));
                end
                #2 rst = 1'b0;
            end
            apply(8'h01, 8'h00, e_t[i]);
            got = obs(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_recount[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_debounce();
        exp_t got, e;
        exp_t e_t[6];
        do_reset();
        deb = 16'd3;
        for (int i = 0; i < 3; i++) e_t[i] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        e_t[3] = mk(8'h01, 8'h01, 8'h00, 8'h00);
        e_t[4] = mk(8'h01, 8'h00, 8'h00, 8'h00);
        e_t[5] = mk(8'h01, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            apply(8'h01, 8'h00, e_t[i]);
            got = obs(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL debounce[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_glitch();
        exp_t got, e;
        logic [7:0] s_t[13];
        exp_t e_t[13];
        do_reset();
        deb = 16'd3;
        for (int i = 0; i < 13; i++) begin
            s_t[i] = (i < 3 || (i >= 4 && i < 8)) ? 8'h02 : 8'h00;
            e_t[i] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        end
        e_t[7]  = mk(8'h02, 8'h02, 8'h00, 8'h00);
        e_t[8]  = mk(8'h02, 8'h00, 8'h00, 8'h00);
        e_t[9]  = mk(8'h02, 8'h00, 8'h00, 8'h00);
        e_t[10] = mk(8'h02, 8'h00, 8'h00, 8'h00);
        e_t[11] = mk(8'h00, 8'h00, 8'h02, 8'h00);
        for (int i = 0; i < 13; i++) begin
            apply(s_t[i], 8'h00, e_t[i]);
            got = obs(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL glitch[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_n0();
        exp_t got, e;
        logic [7:0] s_t[6];
        exp_t e_t[6];
        do_reset();
        deb = 16'd0;
        s_t[0] = 8'h01; e_t[0] = mk(8'h01, 8'h01, 8'h00, 8'h00);
        s_t[1] = 8'h00; e_t[1] = mk(8'h00, 8'h00, 8'h01, 8'h00);
        s_t[2] = 8'h00; e_t[2] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        s_t[3] = 8'hA5; e_t[3] = mk(8'hA5, 8'hA5, 8'h00, 8'h00);
        s_t[4] = 8'h5A; e_t[4] = mk(8'h5A, 8'h5A, 8'hA5, 8'h00);
        s_t[5] = 8'h5A; e_t[5] = mk(8'h5A, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            apply(s_t[i], 8'h00, e_t[i]);
            got = obs(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL n0_passthru[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_irq();
        exp_t got, e;
        logic [7:0] s_t[11], c_t[11], r_t[11], f_t[11];
        exp_t e_t[11];
        do_reset();
        deb = 16'd0;
        s_t[0]  = 8'h01; c_t[0]  = 8'h00; r_t[0]  = 8'h01; f_t[0]  = 8'h00; e_t[0]  = mk(8'h01, 8'h01, 8'h00, 8'h00);
        s_t[1]  = 8'h01; c_t[1]  = 8'h00; r_t[1]  = 8'h01; f_t[1]  = 8'h00; e_t[1]  = mk(8'h01, 8'h00, 8'h00, 8'h01);
        s_t[2]  = 8'h01; c_t[2]  = 8'h00; r_t[2]  = 8'h01; f_t[2]  = 8'h00; e_t[2]  = mk(8'h01, 8'h00, 8'h00, 8'h01);
        s_t[3]  = 8'h00; c_t[3]  = 8'h00; r_t[3]  = 8'h01; f_t[3]  = 8'h00; e_t[3]  = mk(8'h00, 8'h00, 8'h01, 8'h01);
        s_t[4]  = 8'h01; c_t[4]  = 8'h00; r_t[4]  = 8'h01; f_t[4]  = 8'h00; e_t[4]  = mk(8'h01, 8'h01, 8'h00, 8'h01);
        s_t[5]  = 8'h01; c_t[5]  = 8'h01; r_t[5]  = 8'h01; f_t[5]  = 8'h00; e_t[5]  = mk(8'h01, 8'h00, 8'h00, 8'h01);
        s_t[6]  = 8'h01; c_t[6]  = 8'h00; r_t[6]  = 8'h00; f_t[6]  = 8'h00; e_t[6]  = mk(8'h01, 8'h00, 8'h00, 8'h01);
        s_t[7]  = 8'h01; c_t[7]  = 8'h01; r_t[7]  = 8'h00; f_t[7]  = 8'h00; e_t[7]  = mk(8'h01, 8'h00, 8'h00, 8'h00);
        s_t[8]  = 8'h09; c_t[8]  = 8'h00; r_t[8]  = 8'h00; f_t[8]  = 8'h08; e_t[8]  = mk(8'h09, 8'h08, 8'h00, 8'h00);
        s_t[9]  = 8'h01; c_t[9]  = 8'h00; r_t[9]  = 8'h00; f_t[9]  = 8'h08; e_t[9]  = mk(8'h01, 8'h00, 8'h08, 8'h00);
        s_t[10] = 8'h01; c_t[10] = 8'h00; r_t[10] = 8'h00; f_t[10] = 8'h08; e_t[10] = mk(8'h01, 8'h00, 8'h00, 8'h08);
        for (int i = 0; i < 11; i++) begin
            en_r = r_t[i];
            en_f = f_t[i];
            apply(s_t[i], c_t[i], e_t[i]);
            got = obs(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL irq[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
        clr = 8'h00;
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00));
        got = obs(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL irq_reset: got %s, expected %s", fmt(got), fmt(e));
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_threshold_drop();
        exp_t got, e;
        exp_t e_t[6];
        do_reset();
        deb = 16'd10;
        for (int i = 0; i < 5; i++) e_t[i] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        e_t[5] = mk(8'h04, 8'h04, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) deb = 16'd2;
            apply(8'h04, 8'h00, e_t[i]);
            got = obs(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL threshold_drop[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

`ifdef INPUT_COND_BYPASS_EN
    task automatic test_bypass();
        exp_t got, e;
        logic [7:0] s_t[6], b_t[6];
        exp_t e_t[6];
        do_reset();
        deb = 16'd3;
        s_t[0] = 8'h02; b_t[0] = 8'h02; e_t[0] = mk(8'h02, 8'h02, 8'h00, 8'h00);
        s_t[1] = 8'h00; b_t[1] = 8'h02; e_t[1] = mk(8'h00, 8'h00, 8'h02, 8'h00);
        s_t[2] = 8'h02; b_t[2] = 8'h00; e_t[2] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        s_t[3] = 8'h02; b_t[3] = 8'h00; e_t[3] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        s_t[4] = 8'h02; b_t[4] = 8'h00; e_t[4] = mk(8'h00, 8'h00, 8'h00, 8'h00);
        s_t[5] = 8'h02; b_t[5] = 8'h00; e_t[5] = mk(8'h02, 8'h02, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            bypass = b_t[i];
            apply(s_t[i], 8'h00, e_t[i]);
            got = obs(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL bypass[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_n0();
        test_irq();
        test_threshold_drop();
`ifdef INPUT_COND_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
